gs_iter_ctrl: RTL and testbench

Goldschmidt iteration sequencer for the 24-bit divider datapath. Accepts a normalized dividend/divisor pair and time-multiplexes the shared registered 24×24 array multiplier. Each iteration issues N·F and D·F, captures the 48-bit products, and forms the next correction factor F = 2 − D. After a fixed iteration count, it returns the quotient in 1.23 fixed point through a valid/ready output.

---
 rtl/gs_pkg.sv | 24 ++
 rtl/gs_fix_extract.sv | 24 ++
 rtl/gs_iter_ctrl.sv | 114 +++++++++++
 tb/tb_gs_iter_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared types and constants for the Goldschmidt divider sequencer.
package gs_pkg;

   localparam int unsigned W = 24;

   typedef enum logic [2:0] {
      StIdle,
      StIssueN,
      StIssueD,
      StWait,
      StDone
   } gs_state_e;

   localparam logic [W-1:0] GS_ONE       = 24'h800000;
   localparam logic [W-1:0] GS_ERR_Q     = 24'hFFFFFF;
   // A normalized 1.23 divisor in [0.5,1) has top bits 2'b01.
   localparam logic [W-1:0] GS_NORM_MASK = 24'hC00000;
   localparam logic [W-1:0] GS_NORM_VAL  = 24'h400000;

   function automatic logic gs_is_norm(input logic [W-1:0] d);
      return (d & GS_NORM_MASK) == GS_NORM_VAL;
   endfunction

endpackage

// File: rtl/gs_fix_extract.sv
// 2.46 product to 1.23 conversion. Define GS_ROUND_EN for round-half-up with
// saturation; otherwise plain truncation.
module gs_fix_extract
   import gs_pkg::*;
(
   input  logic [2*W-1:0] p,
   output logic [W-1:0]   q
);

`ifdef GS_ROUND_EN
   logic [W:0] sum;
   logic       unused_lsbs;

   assign sum         = {1'b0, p[2*W-2:W-1]} + {{W{1'b0}}, p[W-2]};
   assign q           = (sum[W] || p[2*W-1]) ? GS_ERR_Q : sum[W-1:0];
   assign unused_lsbs = ^p[W-3:0];
`else
   logic unused_bits;

   assign q           = p[2*W-2:W-1];
   assign unused_bits = ^{p[2*W-1], p[W-2:0]};
`endif

endmodule

// File: rtl/gs_iter_ctrl.sv
// Goldschmidt iteration sequencer driving a shared registered multiplier.
// Product extraction mode follows GS_ROUND_EN (see gs_fix_extract).
module gs_iter_ctrl
   import gs_pkg::*;
#(
   parameter int unsigned ITERS   = 5,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   n_in,
   input  logic [W-1:0]   d_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   q_out,
   output logic           err,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_x,
   input  logic [2*W-1:0] mul_p
);

   localparam int unsigned IW = $clog2(ITERS + 1);
   localparam int unsigned CW = $clog2(MUL_LAT + 1);

   gs_state_e     state;
   logic [W-1:0]  n_q, d_q, f_q;
   logic [IW-1:0] iter_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  ext;

   gs_fix_extract u_extract (
      .p (mul_p),
      .q (ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         n_q       <= '0;
         d_q       <= '0;
         f_q       <= '0;
         iter_q    <= '0;
         cnt_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         q_out     <= '0;
         err       <= 1'b0;
         mul_a     <= '0;
         mul_x     <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid) begin
                  n_q      <= n_in;
                  d_q      <= d_in;
                  f_q      <= (~d_in) + W'(1);
                  iter_q   <= '0;
                  in_ready <= 1'b0;
                  if (!gs_is_norm(d_in)) begin
                     q_out     <= GS_ERR_Q;
                     err       <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= StDone;
                  end else begin
                     state <= StIssueN;
                  end
               end
            end
            StIssueN: begin
               mul_a <= n_q;
               mul_x <= f_q;
               state <= StIssueD;
            end
            StIssueD: begin
               mul_a <= d_q;
               mul_x <= f_q;
               cnt_q <= CW'(MUL_LAT - 1);
               state <= StWait;
            end
            StWait: begin
               cnt_q <= cnt_q - CW'(1);
               // N product lands one cycle ahead of the D product.
               if (cnt_q == CW'(1)) begin
                  n_q <= ext;
               end
               if (cnt_q == '0) begin
                  d_q    <= ext;
                  f_q    <= (~ext) + W'(1);
                  iter_q <= iter_q + IW'(1);
                  if (iter_q == IW'(ITERS - 1)) begin
                     q_out     <= n_q;
                     err       <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= StDone;
                  end else begin
                     state <= StIssueN;
                  end
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gs_iter_ctrl.sv
// Directed bench for gs_iter_ctrl with a one-stage registered multiplier model.
module tb_gs_iter_ctrl;
   import gs_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   n_in = '0;
   logic [W-1:0]   d_in = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   q_out;
   logic           err;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_x;
   logic [2*W-1:0] mul_p;

   logic [2*W-1:0] xp;
   logic [W-1:0]   xq;

   int checks = 0;
   int errors = 0;

   gs_iter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .n_in      (n_in),
      .d_in      (d_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q_out     (q_out),
      .err       (err),
      .mul_a     (mul_a),
      .mul_x     (mul_x),
      .mul_p     (mul_p)
   );

   gs_fix_extract u_ext (
      .p (xp),
      .q (xq)
   );

   always #5 clk = ~clk;

   // Operand registers inside the DUT plus this stage give MUL_LAT = 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mul_p <= '0;
      else     mul_p <= {24'b0, mul_a} * {24'b0, mul_x};
   end

`ifdef GS_ROUND_EN
   localparam logic [23:0] Q1_EXP = 24'hC00000;
   localparam logic [23:0] Q2_EXP = 24'h800000;
   localparam logic [23:0] F2_EXP = 24'h800000;
`else
   localparam logic [23:0] Q1_EXP = 24'hBFFFFF;
   localparam logic [23:0] Q2_EXP = 24'h7FFFFF;
   localparam logic [23:0] F2_EXP = 24'h800001;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_div(input logic [23:0] n, input logic [23:0] d, output int lat,
                          output logic [23:0] x1, output logic [23:0] a2,
                          output logic [23:0] x2, output logic [23:0] xl);
      x1 = '0; a2 = '0; x2 = '0; xl = '0;
      in_valid = 1'b1;
      n_in     = n;
      d_in     = d;
      tick();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         if (lat == 2) x1 = mul_x;
         if (lat == 6) begin
            a2 = mul_a;
            x2 = mul_x;
         end
         xl = mul_x;
         tick();
         lat++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL div_timeout: out_valid not seen after %0d cycles, required within 21", lat);
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL handshake_return: in_ready=%b out_valid=%b, required 1 0", in_ready,
                  out_valid);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_out !== 24'h0 || err !== 1'b0 ||
          mul_a !== 24'h0 || mul_x !== 24'h0) begin
         errors++;
         $display("FAIL %s: in_ready=%b out_valid=%b q=%h err=%b a=%h x=%h, required 1 0 0 0 0 0",
                  tag, in_ready, out_valid, q_out, err, mul_a, mul_x);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      check_reset_vals("reset_values");
      rst = 1'b0;
      tick();
      check_reset_vals("idle_after_reset");
   endtask

   task automatic test_divide_basic();
      int lat;
      logic [23:0] x1, a2, x2, xl;
      run_div(24'h600000, 24'h400000, lat, x1, a2, x2, xl);
      checks++;
      if (x1 !== 24'hC00000) begin
         errors++; $display("FAIL first_f: mul_x=%h required C00000", x1);
      end
      checks++;
      if (a2 !== 24'h900000 || x2 !== 24'hA00000) begin
         errors++; $display("FAIL iter2_operands: a=%h x=%h required 900000 A00000", a2, x2);
      end
      checks++;
      if (lat !== 21) begin
         errors++; $display("FAIL latency: %0d cycles, required 21", lat);
      end
      checks++;
      if (q_out !== Q1_EXP || err !== 1'b0) begin
         errors++; $display("FAIL quotient_0p75_0p5: q=%h err=%b required %h 0", q_out, err, Q1_EXP);
      end
      release_out();
   endtask

   task automatic test_divide_equal();
      int lat;
      logic [23:0] x1, a2, x2, xl;
      run_div(24'h555555, 24'h555555, lat, x1, a2, x2, xl);
      checks++;
      if (x1 !== 24'hAAAAAB) begin
         errors++; $display("FAIL equal_first_f: mul_x=%h required AAAAAB", x1);
      end
      checks++;
      if (q_out !== Q2_EXP || err !== 1'b0) begin
         errors++; $display("FAIL quotient_equal: q=%h err=%b required %h 0", q_out, err, Q2_EXP);
      end
      checks++;
      if (xl !== F2_EXP) begin
         errors++; $display("FAIL final_f: mul_x=%h required %h", xl, F2_EXP);
      end
      release_out();
   endtask

   task automatic test_bad_divisor();
      logic [23:0] a0, x0;
      a0 = mul_a;
      x0 = mul_x;
      in_valid = 1'b1;
      n_in     = 24'h600000;
      d_in     = 24'h200000;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || err !== 1'b1 || q_out !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL bad_divisor: valid=%b err=%b q=%h required 1 1 FFFFFF", out_valid, err,
                  q_out);
      end
      checks++;
      if (mul_a !== a0 || mul_x !== x0) begin
         errors++;
         $display("FAIL bad_divisor_mul: a=%h x=%h required %h %h", mul_a, mul_x, a0, x0);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      logic [23:0] x1, a2, x2, xl;
      run_div(24'h600000, 24'h400000, lat, x1, a2, x2, xl);
      in_valid = 1'b1;
      n_in     = 24'h700000;
      d_in     = 24'h500000;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_out !== Q1_EXP || err !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold: %0d unstable cycles, required 0 (q=%h in_ready=%b)",
                  bad, q_out, in_ready);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [23:0] x1, a2, x2, xl;
      in_valid = 1'b1;
      n_in     = 24'h600000;
      d_in     = 24'h400000;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();   // first WAIT cycle of iteration 3
      rst = 1'b1;
      #1;
      check_reset_vals("reset_mid_op");
      tick();
      rst = 1'b0;
      tick();
      check_reset_vals("idle_after_mid_reset");
      run_div(24'h600000, 24'h400000, lat, x1, a2, x2, xl);
      checks++;
      if (lat !== 21 || q_out !== Q1_EXP) begin
         errors++;
         $display("FAIL post_reset_div: lat=%0d q=%h required 21 %h", lat, q_out, Q1_EXP);
      end
      release_out();
   endtask

   task automatic test_extract();
      logic [23:0] e1, e2, e3;
`ifdef GS_ROUND_EN
      e1 = 24'h123457; e2 = 24'hFFFFFF; e3 = 24'hFFFFFF;
`else
      e1 = 24'h123456; e2 = 24'hFFFFFF; e3 = 24'h000010;
`endif
      xp = {1'b0, 24'h123456, 1'b1, 22'h0};
      #1;
      checks++;
      if (xq !== e1) begin
         errors++; $display("FAIL extract_half: q=%h required %h", xq, e1);
      end
      xp = {1'b0, 24'hFFFFFF, 1'b1, 22'h0};
      #1;
      checks++;
      if (xq !== e2) begin
         errors++; $display("FAIL extract_carry: q=%h required %h", xq, e2);
      end
      xp = {1'b1, 24'h000010, 1'b0, 22'h3};
      #1;
      checks++;
      if (xq !== e3) begin
         errors++; $display("FAIL extract_msb: q=%h required %h", xq, e3);
      end
      xp = {1'b0, 24'h400000, 1'b0, 22'h3FFFFF};
      #1;
      checks++;
      if (xq !== 24'h400000) begin
         errors++; $display("FAIL extract_below_half: q=%h required 400000", xq);
      end
   endtask

   initial begin
      xp = '0;
      test_reset();
      test_divide_basic();
      test_divide_equal();
      test_bad_divisor();
      test_backpressure();
      test_reset_mid();
      test_extract();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
